// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one reset-less 16-deep SRL16 FIFO among NREQ writers; grant, write and read are combinational (zero latency).
// Backpressure: acks withheld while busy (INIT/FLUSH) or when full without a same-cycle read; optional FIFO_ARB_STATS_EN adds peak/stall_cnt.
module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ack,
   input  logic                    flush,
   output logic                    fifo_wr,
   output logic [WIDTH-1:0]        fifo_datain,
   output logic                    fifo_rd,
   input  logic [4:0]              fifo_fullness,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [4:0]              peak,
   output logic [15:0]             stall_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW:0] NREQ_C  = (PW+1)'(NREQ);
   localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_t;

   state_t        state_q, state_d, cur;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d, winner;
   logic [PW:0]   idx, nxt;
   logic          found, space;

   // First requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (idx >= NREQ_C) idx = idx - NREQ_C;
         if (!found && req[idx[PW-1:0]]) begin
            found  = 1'b1;
            winner = idx[PW-1:0];
         end
      end
      nxt = {1'b0, winner} + {{PW{1'b0}}, 1'b1};
      if (nxt >= NREQ_C) nxt = '0;
   end

   // Reset forces the INIT view of the outputs even before the state register settles.
   always_comb begin
      cur         = rst ? S_INIT : state_q;
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      req_ack     = '0;
      fifo_wr     = 1'b0;
      fifo_datain = '0;
      fifo_rd     = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      space       = 1'b0;
      case (cur)
         S_RUN: begin
            busy      = 1'b0;
            out_valid = (fifo_fullness != 5'd0);
            fifo_rd   = out_valid & out_ready;
            space     = (fifo_fullness < DEPTH_C) | fifo_rd;
            if (space && found) begin
               req_ack[winner] = 1'b1;
               fifo_wr         = 1'b1;
               rr_ptr_d        = nxt[PW-1:0];
            end
            if (flush) state_d = S_FLUSH;
         end
         default: begin
            fifo_rd = (fifo_fullness != 5'd0);
            if (fifo_fullness == 5'd0) state_d = S_RUN;
         end
      endcase
      for (int i = 0; i < NREQ; i++) begin
         if (req_ack[i]) fifo_datain = req_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_INIT;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [4:0]  peak_q, peak_d;
   logic [15:0] stall_q, stall_d;

   always_comb begin
      peak_d  = peak_q;
      stall_d = stall_q;
      if (cur == S_RUN) begin
         if (fifo_fullness > peak_q) peak_d = fifo_fullness;
         if ((|req) && !fifo_wr && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
         if (flush) begin
            peak_d  = '0;
            stall_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         peak_q  <= '0;
         stall_q <= '0;
      end else begin
         peak_q  <= peak_d;
         stall_q <= stall_d;
      end
   end

   assign peak      = peak_q;
   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural SRL16 FIFO stand-in, spec-level reference model and data scoreboard.
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;

   logic        clk = 1'b1;
   logic        rst, flush, out_ready;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic        fifo_wr, fifo_rd, out_valid, busy;
   logic [7:0]  fifo_datain;
   logic [4:0]  fifo_fullness;
`ifdef FIFO_ARB_STATS_EN
   logic [4:0]  peak;
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
      .flush(flush), .fifo_wr(fifo_wr), .fifo_datain(fifo_datain), .fifo_rd(fifo_rd),
      .fifo_fullness(fifo_fullness), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
`ifdef FIFO_ARB_STATS_EN
      , .peak(peak), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reset-less FIFO stand-in, preloaded with 7 stale entries.
   logic [7:0] mem [0:15];
   logic [3:0] head = 4'd0;
   logic [4:0] cnt  = 5'd7;
   logic [7:0] fifo_dout;
   assign fifo_fullness = cnt;
   assign fifo_dout     = mem[head];

   always @(posedge clk) begin
      if (fifo_wr) mem[head + cnt[3:0]] <= fifo_datain;
      if (fifo_rd) head <= head + 4'd1;
      cnt <= cnt + {4'd0, fifo_wr} - {4'd0, fifo_rd};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted output must be the oldest predicted write.
   logic [7:0] exp_q[$];
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_empty: got %0h expected no valid data", fifo_dout);
         end else begin
            chk("data_order", 32'(fifo_dout), 32'(exp_q.pop_front()));
         end
      end
   end

   // Reference model: mode 0=INIT 1=RUN 2=FLUSH, round-robin pointer kept as an integer.
   int m_mode = 0;
   int m_ptr  = 0;
   always @(negedge clk) begin
      int mode, win;
      logic [3:0] e_ack;
      logic e_wr, e_rd, e_valid, e_busy;
      #1;
      mode  = rst ? 0 : m_mode;
      e_ack = 4'd0;
      e_wr  = 1'b0;
      win   = -1;
      if (mode == 1) begin
         e_valid = (cnt != 0);
         e_rd    = e_valid && out_ready;
         e_busy  = 1'b0;
         if ((cnt < 16 || e_rd) && req != 4'd0) begin
            for (int k = 0; k < NREQ; k++)
               if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            e_ack = 4'(1 << win);
            e_wr  = 1'b1;
         end
      end else begin
         e_valid = 1'b0;
         e_rd    = (cnt != 0);
         e_busy  = 1'b1;
      end
      chk("req_ack", 32'(req_ack), 32'(e_ack));
      chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
      chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("busy", 32'(busy), 32'(e_busy));
      if (e_wr) begin
         chk("fifo_datain", 32'(fifo_datain), 32'(req_data[win*8 +: 8]));
         exp_q.push_back(req_data[win*8 +: 8]);
      end
      if (rst) begin
         m_mode = 0;
         m_ptr  = 0;
         exp_q.delete();
      end else if (mode == 1) begin
         if (win >= 0) m_ptr = (win + 1) % NREQ;
         if (flush) begin
            m_mode = 2;
            exp_q.delete();
         end
      end else if (cnt == 0) begin
         m_mode = 1;
      end
   end

   task automatic write_n(input int w, input int n, input logic [7:0] d);
      int got = 0;
      int guard = 0;
      req[w] = 1'b1;
      req_data[w*8 +: 8] = d;
      while (got < n && guard < 100) begin
         @(negedge clk);
         if (req_ack[w]) got++;
         guard++;
         @(posedge clk); #1;
      end
      req[w] = 1'b0;
      chk("write_n_acks", 32'(got), 32'(n));
   endtask

   int rdc, busyc, ackc, waited;
   logic done, got1;
   logic [3:0] ackv;

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      req = 4'hF; req_data = {8'h13, 8'h12, 8'h11, 8'h10};

      // Reset with 7 stale entries: INIT drains them, no grants.
      rdc = 0; busyc = 0; ackc = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
         else begin
            busyc++;
            if (fifo_rd) rdc++;
            if (req_ack != 4'd0) ackc++;
         end
         if (!done) begin @(posedge clk); #1; rst = 1'b0; end
      end
      chk("init_done", 32'(done), 32'd1);
      chk("init_reads", rdc, 7);
      chk("init_busy_cycles", busyc, 8);
      chk("init_acks", ackc, 0);

      // Four writers held with out_ready low: round-robin until full.
      ackc = 0;
      for (int c = 0; c < 20; c++) begin
         if (req_ack != 4'd0) begin
            chk("rr_order", 32'(req_ack), 32'(1 << (ackc % 4)));
            ackc++;
         end
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("fill_acks", ackc, 16);
      chk("fill_fullness", 32'(cnt), 32'd16);

      // Full with a simultaneous read: write still granted.
      @(posedge clk); #1;
      req = 4'b0100; req_data[23:16] = 8'h55; out_ready = 1'b1;
      @(negedge clk);
      chk("full_rd_ack", 32'(req_ack), 32'h4);
      chk("full_rd_wr", 32'(fifo_wr), 32'd1);
      chk("full_rd_rd", 32'(fifo_rd), 32'd1);
      @(posedge clk); #1;
      req = 4'd0;
      chk("full_rd_fullness", 32'(cnt), 32'd16);
      for (int c = 0; c < 40 && cnt != 0; c++) begin @(posedge clk); #1; end
      chk("drain_empty", 32'(cnt), 32'd0);

      // Empty with out_ready high: no read.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("empty_rd", 32'(fifo_rd), 32'd0);
         chk("empty_valid", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      chk("empty_fullness", 32'(cnt), 32'd0);

      // Fullness 9 then flush while writer 1 waits.
      out_ready = 1'b0;
      write_n(0, 9, 8'hA0);
      chk("pre_flush_fullness", 32'(cnt), 32'd9);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; req[1] = 1'b1; req_data[15:8] = 8'hB1;
      waited = 0; rdc = 0; ackc = 0; got1 = 1'b0;
      for (int c = 0; c < 40 && !got1; c++) begin
         @(negedge clk);
         if (req_ack[1]) got1 = 1'b1;
         else begin
            waited++;
            if (fifo_rd) rdc++;
            if (req_ack != 4'd0) ackc++;
         end
         @(posedge clk); #1;
      end
      req[1] = 1'b0;
      chk("flush_ack_after", 32'(got1), 32'd1);
      chk("flush_wait_cycles", waited, 10);
      chk("flush_reads", rdc, 9);
      chk("flush_no_acks", ackc, 0);

      // Statistics: flush clears, fill to 12, drain, then stall while full.
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      for (int c = 0; c < 40 && busy; c++) begin @(posedge clk); #1; end
      write_n(3, 12, 8'hC3);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 40 && cnt != 0; c++) begin @(posedge clk); #1; end
`ifdef FIFO_ARB_STATS_EN
      chk("peak_12", 32'(peak), 32'd12);
      chk("stall_0", 32'(stall_cnt), 32'd0);
`endif
      out_ready = 1'b0;
      write_n(2, 16, 8'hD2);
      req[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
      req[2] = 1'b0;
`ifdef FIFO_ARB_STATS_EN
      chk("stall_3", 32'(stall_cnt), 32'd3);
      chk("peak_16", 32'(peak), 32'd16);
`endif
      out_ready = 1'b1;
      for (int c = 0; c < 40 && cnt != 0; c++) begin @(posedge clk); #1; end

      // Randomized traffic with occasional flush and reset.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         ackv = req_ack;
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || ackv[i]) begin
               req[i] = ($urandom_range(0, 2) == 0);
               req_data[i*8 +: 8] = 8'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 1) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 149) == 0);
      end
      rst = 1'b0; req = 4'd0; flush = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin @(posedge clk); #1; end
      chk("final_fullness", 32'(cnt), 32'd0);
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
